// File: rtl/id_ex_skid_reg_pkg.sv
// Shared types and helpers for the ID/EX skid register.
// Holds the control-bundle struct, the all-zero bubble constant and the
// default field widths used by the top and its entry sub-module.
package id_ex_skid_reg_pkg;

  localparam int FUNCT_W_DEF = 4;
  localparam int ALUOP_W_DEF = 2;

  typedef struct packed {
    logic                   branch;
    logic                   memread;
    logic                   memtoreg;
    logic                   memwrite;
    logic                   alusrc;
    logic                   regwrite;
    logic [ALUOP_W_DEF-1:0] aluop;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  // Increment that sticks at the maximum value instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/id_ex_skid_reg_if.sv
// Handshake and payload bundle between decode, the ID/EX register and execute.
// master: the side driving the decode inputs and the EX ready (a bench or glue).
// slave : the ID/EX register itself.
interface id_ex_skid_reg_if #(
  parameter int XLEN    = 64,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = 4,
  parameter int ALUOP_W = 2
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic [XLEN-1:0]    in_imm;
  logic [REG_AW-1:0]  in_rs1;
  logic [REG_AW-1:0]  in_rs2;
  logic [REG_AW-1:0]  in_rd;
  logic [FUNCT_W-1:0] in_funct;
  logic               in_branch;
  logic               in_memread;
  logic               in_memtoreg;
  logic               in_memwrite;
  logic               in_alusrc;
  logic               in_regwrite;
  logic [ALUOP_W-1:0] in_aluop;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_rs1_data;
  logic [XLEN-1:0]    out_rs2_data;
  logic [XLEN-1:0]    out_imm;
  logic [REG_AW-1:0]  out_rs1;
  logic [REG_AW-1:0]  out_rs2;
  logic [REG_AW-1:0]  out_rd;
  logic [FUNCT_W-1:0] out_funct;
  logic               out_branch;
  logic               out_memread;
  logic               out_memtoreg;
  logic               out_memwrite;
  logic               out_alusrc;
  logic               out_regwrite;
  logic [ALUOP_W-1:0] out_aluop;

  modport master (
    output flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_funct, in_branch, in_memread,
           in_memtoreg, in_memwrite, in_alusrc, in_regwrite, in_aluop,
           out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_funct, out_branch, out_memread,
           out_memtoreg, out_memwrite, out_alusrc, out_regwrite, out_aluop
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_funct, in_branch, in_memread,
           in_memtoreg, in_memwrite, in_alusrc, in_regwrite, in_aluop,
           out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_funct, out_branch, out_memread,
           out_memtoreg, out_memwrite, out_alusrc, out_regwrite, out_aluop
  );
endinterface

// File: rtl/id_ex_skid_reg_entry.sv
// id_ex_entry: one valid+payload slot of the ID/EX register.
// Writing the slot invalid (clear, or load with d_valid=0) always stores the
// bubble control bundle so a dead slot can never trigger a store/writeback.
// Data bits keep their last value on clear; reset zeroes everything.
module id_ex_entry
  import id_ex_skid_reg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              d_valid,
  input  logic [DATA_W-1:0] d_data,
  input  id_ex_ctrl_t       d_ctrl,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output id_ex_ctrl_t       q_ctrl
);

  // Slot state: reset > clear > load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_ctrl  <= CTRL_BUBBLE;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_ctrl  <= CTRL_BUBBLE;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= d_data;
      q_ctrl  <= d_valid ? d_ctrl : CTRL_BUBBLE;
    end
  end

endmodule

// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: ID/EX pipeline register with valid/ready handshake,
// a 2-entry skid buffer (main M feeds EX, skid S catches one extra entry
// when EX stalls), flush, bubble-safe control and an x0 writeback guard.
// in_ready is ~S.valid, so there is no combinational ready path from EX.
// Optional macro ID_EX_SKID_PERF_EN adds saturating stall/flush counters.
// The aluop field width is carried by the shared package control struct.
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int REG_AW  = 5,
  parameter int FUNCT_W = FUNCT_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic clk,
  input  logic reset,
  id_ex_skid_reg_if.slave bus
`ifdef ID_EX_SKID_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  localparam int PAY_W = 4 * XLEN + 3 * REG_AW + FUNCT_W;

  logic [PAY_W-1:0] in_pay, m_pay, s_pay, m_dpay;
  id_ex_ctrl_t      in_ctrl, m_ctrl, s_ctrl, m_dctrl;
  logic             m_valid, s_valid;
  logic             m_load, m_clear, m_dvalid, s_load, s_clear;
  logic             accept, drain;

  assign in_pay = {bus.in_pc, bus.in_rs1_data, bus.in_rs2_data, bus.in_imm,
                   bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_funct};

  // Incoming control bundle; a write to x0 is never a real writeback.
  always_comb begin
    in_ctrl          = CTRL_BUBBLE;
    in_ctrl.branch   = bus.in_branch;
    in_ctrl.memread  = bus.in_memread;
    in_ctrl.memtoreg = bus.in_memtoreg;
    in_ctrl.memwrite = bus.in_memwrite;
    in_ctrl.alusrc   = bus.in_alusrc;
    in_ctrl.regwrite = bus.in_regwrite & (bus.in_rd != '0);
    in_ctrl.aluop    = ALUOP_W_DEF'(bus.in_aluop);
  end

  assign accept = bus.in_valid & ~s_valid;
  assign drain  = m_valid & bus.out_ready;

  // Steering: flush kills both slots; M refills from S first, else from input;
  // input goes to S only while M is stuck full.
  always_comb begin
    m_load   = 1'b0;
    m_clear  = bus.flush;
    m_dvalid = accept;
    m_dpay   = in_pay;
    m_dctrl  = in_ctrl;
    s_load   = 1'b0;
    s_clear  = bus.flush;
    if (!bus.flush) begin
      if (!m_valid || drain) begin
        m_load = 1'b1;
        if (s_valid) begin
          m_dvalid = 1'b1;
          m_dpay   = s_pay;
          m_dctrl  = s_ctrl;
          s_clear  = 1'b1;
        end
      end else if (accept) begin
        s_load = 1'b1;
      end
    end
  end

  id_ex_entry #(.DATA_W(PAY_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (m_clear),
    .load    (m_load),
    .d_valid (m_dvalid),
    .d_data  (m_dpay),
    .d_ctrl  (m_dctrl),
    .q_valid (m_valid),
    .q_data  (m_pay),
    .q_ctrl  (m_ctrl)
  );

  id_ex_entry #(.DATA_W(PAY_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clear   (s_clear),
    .load    (s_load),
    .d_valid (1'b1),
    .d_data  (in_pay),
    .d_ctrl  (in_ctrl),
    .q_valid (s_valid),
    .q_data  (s_pay),
    .q_ctrl  (s_ctrl)
  );

  assign bus.in_ready  = ~s_valid;
  assign bus.out_valid = m_valid;
  assign {bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_imm,
          bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_funct} = m_pay;
  assign bus.out_branch   = m_ctrl.branch;
  assign bus.out_memread  = m_ctrl.memread;
  assign bus.out_memtoreg = m_ctrl.memtoreg;
  assign bus.out_memwrite = m_ctrl.memwrite;
  assign bus.out_alusrc   = m_ctrl.alusrc;
  assign bus.out_regwrite = m_ctrl.regwrite;
  assign bus.out_aluop    = ALUOP_W'(m_ctrl.aluop);

`ifdef ID_EX_SKID_PERF_EN
  // Saturating counters: EX stall cycles, and flushes that killed live work.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (m_valid && !bus.out_ready)
        perf_stall_cycles <= sat_inc32(perf_stall_cycles);
      if (bus.flush && (m_valid || s_valid))
        perf_flush_count <= sat_inc32(perf_flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg: a vector table of single-cycle steps
// with hand-computed outputs, an ordering sequence against a queue model,
// and (with ID_EX_SKID_PERF_EN) a counter sequence.
module tb_id_ex_skid_reg;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_mis;

  id_ex_skid_reg_if #(.XLEN(64), .REG_AW(5), .FUNCT_W(4), .ALUOP_W(2)) bus ();

`ifdef ID_EX_SKID_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  id_ex_skid_reg #(.XLEN(64), .REG_AW(5), .FUNCT_W(4), .ALUOP_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ID_EX_SKID_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fl, iv;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, ordy;
    logic        e_ov;
    logic [63:0] e_pc;
    logic        e_irdy, e_rw, e_mr, e_mw;
  } vec_t;

  function automatic vec_t v(input logic rst, fl, iv, input logic [63:0] pc,
                             input logic [4:0] rd, input logic rw, mr, mw, ordy,
                             input logic e_ov, input logic [63:0] e_pc,
                             input logic e_irdy, e_rw, e_mr, e_mw);
    vec_t r;
    r.rst = rst; r.fl = fl; r.iv = iv; r.pc = pc; r.rd = rd;
    r.rw = rw; r.mr = mr; r.mw = mw; r.ordy = ordy;
    r.e_ov = e_ov; r.e_pc = e_pc; r.e_irdy = e_irdy;
    r.e_rw = e_rw; r.e_mr = e_mr; r.e_mw = e_mw;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Other payload fields are derived from pc so they can be re-derived on the output.
  task automatic set_in(input logic iv, input logic [63:0] pc, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
    bus.in_valid    = iv;
    bus.in_pc       = pc;
    bus.in_rs1_data = pc ^ 64'hA5A5_5A5A_0F0F_F0F0;
    bus.in_rs2_data = pc + 64'd7;
    bus.in_imm      = ~pc;
    bus.in_rs1      = pc[6:2];
    bus.in_rs2      = pc[7:3];
    bus.in_rd       = rd;
    bus.in_funct    = pc[5:2];
    bus.in_branch   = pc[4];
    bus.in_memread  = mr;
    bus.in_memtoreg = mr;
    bus.in_memwrite = mw;
    bus.in_alusrc   = 1'b1;
    bus.in_regwrite = rw;
    bus.in_aluop    = pc[3:2];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 23;
  vec_t vecs[NV];

  initial begin
    logic [63:0] q[$];
    logic [63:0] next_pc;
    logic [63:0] exp_pc;
    logic        acc, drn;

    n_vec = 0;
    n_mis = 0;

    //       rst fl iv pc      rd rw mr mw ordy | ov  pc      irdy rw mr mw
    vecs[0]  = v(1, 0, 1, 'h50,  1, 1, 0, 0, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[1]  = v(1, 0, 1, 'h54,  1, 1, 0, 0, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[2]  = v(0, 0, 1, 'h100, 1, 1, 0, 0, 1,   1, 'h100, 1, 1, 0, 0);
    vecs[3]  = v(0, 0, 1, 'h104, 1, 1, 0, 0, 1,   1, 'h104, 1, 1, 0, 0);
    vecs[4]  = v(0, 0, 1, 'h108, 1, 1, 0, 0, 1,   1, 'h108, 1, 1, 0, 0);
    vecs[5]  = v(0, 0, 0, 'h0,   1, 1, 0, 1, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[6]  = v(0, 0, 1, 'h200, 1, 1, 0, 0, 0,   1, 'h200, 1, 1, 0, 0);
    vecs[7]  = v(0, 0, 1, 'h204, 1, 1, 0, 0, 0,   1, 'h200, 0, 1, 0, 0);
    vecs[8]  = v(0, 0, 1, 'h208, 1, 1, 0, 0, 0,   1, 'h200, 0, 1, 0, 0);
    vecs[9]  = v(0, 0, 1, 'h208, 1, 1, 0, 0, 1,   1, 'h204, 1, 1, 0, 0);
    vecs[10] = v(0, 0, 1, 'h208, 1, 1, 0, 0, 1,   1, 'h208, 1, 1, 0, 0);
    vecs[11] = v(0, 0, 0, 'h0,   1, 1, 0, 1, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[12] = v(0, 0, 1, 'h300, 1, 1, 0, 1, 0,   1, 'h300, 1, 1, 0, 1);
    vecs[13] = v(0, 0, 1, 'h304, 1, 1, 0, 1, 0,   1, 'h300, 0, 1, 0, 1);
    vecs[14] = v(0, 1, 1, 'h308, 1, 1, 0, 1, 0,   0, 'h0,   1, 0, 0, 0);
    vecs[15] = v(0, 0, 0, 'h0,   1, 1, 0, 1, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[16] = v(0, 1, 1, 'h30c, 1, 1, 0, 1, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[17] = v(0, 0, 0, 'h0,   1, 1, 0, 1, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[18] = v(0, 0, 1, 'h400, 0, 1, 1, 0, 1,   1, 'h400, 1, 0, 1, 0);
    vecs[19] = v(0, 0, 1, 'h404, 5, 1, 0, 0, 1,   1, 'h404, 1, 1, 0, 0);
    vecs[20] = v(0, 0, 1, 'h408, 1, 1, 0, 0, 1,   1, 'h408, 1, 1, 0, 0);
    vecs[21] = v(1, 1, 1, 'h40c, 1, 1, 0, 1, 1,   0, 'h0,   1, 0, 0, 0);
    vecs[22] = v(0, 0, 1, 'h500, 1, 1, 0, 0, 1,   1, 'h500, 1, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      reset         = vecs[i].rst;
      bus.flush     = vecs[i].fl;
      bus.out_ready = vecs[i].ordy;
      set_in(vecs[i].iv, vecs[i].pc, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].mw);
      tick();
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].e_irdy));
      chk($sformatf("v%0d out_regwrite", i), 64'(bus.out_regwrite), 64'(vecs[i].e_rw));
      chk($sformatf("v%0d out_memread", i), 64'(bus.out_memread), 64'(vecs[i].e_mr));
      chk($sformatf("v%0d out_memtoreg", i), 64'(bus.out_memtoreg), 64'(vecs[i].e_mr));
      chk($sformatf("v%0d out_memwrite", i), 64'(bus.out_memwrite), 64'(vecs[i].e_mw));
      chk($sformatf("v%0d out_alusrc", i), 64'(bus.out_alusrc), 64'(vecs[i].e_ov));
      chk($sformatf("v%0d out_branch", i), 64'(bus.out_branch),
          64'(vecs[i].e_ov & vecs[i].e_pc[4]));
      chk($sformatf("v%0d out_aluop", i), 64'(bus.out_aluop),
          vecs[i].e_ov ? 64'(vecs[i].e_pc[3:2]) : 64'd0);
      if (vecs[i].rst) begin
        chk($sformatf("v%0d out_pc", i), bus.out_pc, 64'd0);
        chk($sformatf("v%0d out_imm", i), bus.out_imm, 64'd0);
        chk($sformatf("v%0d out_rs2_data", i), bus.out_rs2_data, 64'd0);
        chk($sformatf("v%0d out_rd", i), 64'(bus.out_rd), 64'd0);
      end else if (vecs[i].e_ov) begin
        chk($sformatf("v%0d out_pc", i), bus.out_pc, vecs[i].e_pc);
        chk($sformatf("v%0d out_imm", i), bus.out_imm, ~vecs[i].e_pc);
        chk($sformatf("v%0d out_rs1_data", i), bus.out_rs1_data,
            vecs[i].e_pc ^ 64'hA5A5_5A5A_0F0F_F0F0);
        chk($sformatf("v%0d out_rs2_data", i), bus.out_rs2_data, vecs[i].e_pc + 64'd7);
        chk($sformatf("v%0d out_funct", i), 64'(bus.out_funct), 64'(vecs[i].e_pc[5:2]));
        chk($sformatf("v%0d out_rs1", i), 64'(bus.out_rs1), 64'(vecs[i].e_pc[6:2]));
      end
    end

    // Ordering under random valid/ready: queue model of accepted pcs.
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 64'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    next_pc = 64'h1000;
    for (int c = 0; c < 200; c++) begin
      logic drain_phase;
      drain_phase = (c >= 180);
      if (drain_phase && q.size() == 0) break;
      set_in(drain_phase ? 1'b0 : 1'($urandom_range(0, 1)), next_pc, 5'd3, 1'b1, 1'b0, 1'b0);
      bus.out_ready = drain_phase ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      acc = bus.in_valid & bus.in_ready;
      drn = bus.out_valid & bus.out_ready;
      if (drn) begin
        if (q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL order c%0d: got out_pc %0h expected no entry", c, bus.out_pc);
        end else begin
          exp_pc = q.pop_front();
          chk($sformatf("order c%0d out_pc", c), bus.out_pc, exp_pc);
        end
      end
      if (acc) begin
        q.push_back(next_pc);
        next_pc = next_pc + 64'd4;
      end
      tick();
      chk($sformatf("order c%0d out_valid", c), 64'(bus.out_valid), 64'(q.size() != 0));
      chk($sformatf("order c%0d in_ready", c), 64'(bus.in_ready), 64'(q.size() < 2));
    end
    chk("order drained", 64'(q.size()), 64'd0);
    chk("order tail out_valid", 64'(bus.out_valid), 64'd0);

`ifdef ID_EX_SKID_PERF_EN
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 64'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    chk("perf reset stall", 64'(perf_stall_cycles), 64'd0);
    chk("perf reset flush", 64'(perf_flush_count), 64'd0);
    set_in(1'b1, 64'h600, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 64'h0, 5'd1, 1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    set_in(1'b1, 64'h604, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 64'h0, 5'd1, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    tick();
    tick();
    bus.flush = 1'b0;
    chk("perf stall cycles", 64'(perf_stall_cycles), 64'd7);
    chk("perf flush count", 64'(perf_flush_count), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
